// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, forward-select encodings and hazard FSM states.
package mips_pkg;

    localparam logic [5:0] OpAlu  = 6'd0;
    localparam logic [5:0] OpJ    = 6'd2;
    localparam logic [5:0] OpJal  = 6'd3;
    localparam logic [5:0] OpAddi = 6'd8;
    localparam logic [5:0] OpLw   = 6'd35;
    localparam logic [5:0] OpSw   = 6'd43;

    localparam logic [1:0] FwdRf    = 2'b00;
    localparam logic [1:0] FwdMemWb = 2'b01;
    localparam logic [1:0] FwdExMem = 2'b10;

    typedef enum logic {StRun, StStall} hz_state_e;

    function automatic logic reads_rs(input logic [5:0] op);
        logic r;
        case (op)
            OpAlu, OpLw, OpSw, OpAddi: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dest_decode.sv
// Destination-register decode for one instruction word; register 0 never counts as a destination.
module dest_decode
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  dst,
    output logic        has_dst,
    output logic        is_load
);

    logic [5:0] op;
    assign op = ir[31:26];

    always_comb begin
        dst = 5'd0;
        case (op)
            OpAlu:        dst = ir[15:11];
            OpLw, OpAddi: dst = ir[20:16];
            OpJal:        dst = 5'd31;
            default:      dst = 5'd0;
        endcase
        has_dst = (dst != 5'd0);
        is_load = (op == OpLw) && has_dst;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit: tracks EX/MEM destinations and registers
// ALU operand selects for the instruction entering EX.
module fwd_hazard_unit
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [31:0] id_ir,
    input  logic        hold,
    input  logic        flush,
    output logic [1:0]  fa,
    output logic [1:0]  fb,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    hz_state_e   state_q, state_d;
    logic [4:0]  ex_dst_q, mem_dst_q;
    logic        ex_v_q, ex_ld_q, mem_v_q;
    logic [1:0]  fa_q, fb_q, fa_d, fb_d;
    logic [15:0] cnt_q;

    logic [4:0]  id_dst;
    logic        id_has_dst, id_is_load;

    dest_decode u_dest_decode (
        .ir      (id_ir),
        .dst     (id_dst),
        .has_dst (id_has_dst),
        .is_load (id_is_load)
    );

    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       rd_rs, rd_rt, load_use, take_id;

    assign op    = id_ir[31:26];
    assign rs    = id_ir[25:21];
    assign rt    = id_ir[20:16];
    assign rd_rs = reads_rs(op);
    assign rd_rt = (op == OpAlu);

    // EX match checked first so the younger producer wins on a double match.
    always_comb begin
        fa_d = FwdRf;
        fb_d = FwdRf;
        if (rd_rs) begin
            if (ex_v_q && ex_dst_q == rs)        fa_d = FwdExMem;
            else if (mem_v_q && mem_dst_q == rs) fa_d = FwdMemWb;
        end
        if (rd_rt) begin
            if (ex_v_q && ex_dst_q == rt)        fb_d = FwdExMem;
            else if (mem_v_q && mem_dst_q == rt) fb_d = FwdMemWb;
        end
    end

    assign load_use = id_valid && !flush && ex_v_q && ex_ld_q &&
                      ((rd_rs && ex_dst_q == rs) || (rd_rt && ex_dst_q == rt));

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        if (!hold) begin
            case (state_q)
                StRun: begin
                    if (load_use) begin
                        stall   = 1'b1;
                        state_d = StStall;
                    end
                end
                StStall: state_d = StRun;
                default: state_d = StRun;
            endcase
        end
    end

    assign take_id = id_valid && !flush && !stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StRun;
            ex_dst_q  <= 5'd0;
            ex_v_q    <= 1'b0;
            ex_ld_q   <= 1'b0;
            mem_dst_q <= 5'd0;
            mem_v_q   <= 1'b0;
            fa_q      <= FwdRf;
            fb_q      <= FwdRf;
            cnt_q     <= 16'd0;
        end else if (!hold) begin
            state_q   <= state_d;
            mem_dst_q <= ex_dst_q;
            mem_v_q   <= ex_v_q;
            ex_dst_q  <= id_dst;
            ex_v_q    <= take_id && id_has_dst;
            ex_ld_q   <= take_id && id_is_load;
            fa_q      <= take_id ? fa_d : FwdRf;
            fb_q      <= take_id ? fb_d : FwdRf;
            if (stall && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign fa        = fa_q;
    assign fb        = fb_q;
    assign stall_cnt = cnt_q;

endmodule
